baggage_drop_seq: RTL and testbench

- Clocked, parametrised successor to the combinational baggage drop controller. It takes N_SENS height sensors, averages the non-zero readings, and computes the fall time t = sqrt(height)/2 as a fixed-point value.
- The average uses a sequential restoring divider; the square root uses an iterative digit-by-digit unit. The result is compared against t_lim to decide drop/lock.
- Drives four seven-segment digits plus drop_activated, and uses a start/busy/done handshake toward the kiosk controller.

---
 rtl/baggage_drop_seq.sv | 214 +++++++++++++++++++++
 tb/tb_baggage_drop_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baggage_drop_seq.sv
// Sequential baggage drop controller: averages non-zero sensors, computes t = sqrt(height)/2.
// Define BAGGAGE_DROP_DIAG_EN to add the height_out / valid_cnt diagnostic ports.
module baggage_drop_seq #(
    parameter int N_SENS = 4,
    parameter int SW     = 8,
    parameter int FRAC   = 8,
    parameter int TW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_SENS*SW-1:0] sensors,
    input  logic [TW-1:0]        t_lim,
    input  logic                 drop_en,
    output logic                 busy,
    output logic                 done,
    output logic [TW-1:0]        t_out,
    output logic                 drop_activated,
    output logic [6:0]           seven_seg1,
    output logic [6:0]           seven_seg2,
    output logic [6:0]           seven_seg3,
    output logic [6:0]           seven_seg4
`ifdef BAGGAGE_DROP_DIAG_EN
    ,
    output logic [SW-1:0]        height_out,
    output logic [4:0]           valid_cnt
`endif
);

    localparam int SUMW = SW + $clog2(N_SENS);
    localparam int CW   = $clog2(N_SENS + 1);
    localparam int DW   = SUMW + CW;
    localparam int XW   = SW + 2 * FRAC;
    localparam int RW   = SW / 2 + FRAC;
    localparam int SQ   = XW / 2;

    typedef enum logic [2:0] {IDLE, SUM, CHK, DIV, SQRT, DEC, ERR} state_t;

    state_t                r_state;
    logic [N_SENS*SW-1:0]  r_sens;
    logic [TW-1:0]         r_tLim;
    logic                  r_dropEn;
    logic [SUMW-1:0]       r_sum;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_step;
    logic [DW-1:0]         r_num;
    logic [DW-1:0]         r_den;
    logic [XW-1:0]         r_x;
    logic [XW-1:0]         r_res;
    logic [XW-1:0]         r_bit;
    logic                  r_busy;
    logic                  r_done;
    logic [TW-1:0]         r_tOut;
    logic                  r_drop;
    logic [27:0]           r_seg;
`ifdef BAGGAGE_DROP_DIAG_EN
    logic [SW-1:0]         r_height;
    logic [SW-1:0]         r_heightOut;
    logic [4:0]            r_validCnt;
`endif

    logic [SW-1:0]         w_curSens;
    logic                  w_divGe;
    logic [XW-1:0]         w_trial;
    logic                  w_sqGe;
    logic [TW-1:0]         w_tVal;
    logic                  w_drop;

    assign w_curSens = r_sens[SW-1:0];
    assign w_divGe   = (r_num >= r_den);
    assign w_trial   = r_res + r_bit;
    assign w_sqGe    = (r_x >= w_trial);
    assign w_tVal    = TW'(r_res[RW-1:1]);
    assign w_drop    = r_dropEn & (w_tVal <= r_tLim);

    // Division shifts the divisor down one bit per cycle; quotient bits land
    // directly in the square-root radicand, already scaled by 2*FRAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sens   <= '0;
            r_tLim   <= '0;
            r_dropEn <= 1'b0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_step   <= '0;
            r_num    <= '0;
            r_den    <= '0;
            r_x      <= '0;
            r_res    <= '0;
            r_bit    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tOut   <= '0;
            r_drop   <= 1'b0;
            r_seg    <= '0;
`ifdef BAGGAGE_DROP_DIAG_EN
            r_height    <= '0;
            r_heightOut <= '0;
            r_validCnt  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !r_done) begin
                        r_sens   <= sensors;
                        r_tLim   <= t_lim;
                        r_dropEn <= drop_en;
                        r_sum    <= '0;
                        r_cnt    <= '0;
                        r_step   <= 8'(N_SENS - 1);
                        r_busy   <= 1'b1;
                        r_state  <= SUM;
                    end
                end
                SUM: begin
                    if (w_curSens != '0) begin
                        r_sum <= r_sum + SUMW'(w_curSens);
                        r_cnt <= r_cnt + CW'(1);
                    end
                    r_sens <= r_sens >> SW;
                    if (r_step == 8'd0) begin
                        r_state <= CHK;
                    end else begin
                        r_step <= r_step - 8'd1;
                    end
                end
                CHK: begin
                    r_num  <= DW'(r_sum);
                    r_den  <= DW'(r_cnt) << (SUMW - 1);
                    r_x    <= '0;
                    r_res  <= '0;
                    r_bit  <= XW'(1) << (XW - 2);
                    r_step <= 8'(SUMW - 1);
`ifdef BAGGAGE_DROP_DIAG_EN
                    r_height <= '0;
`endif
                    r_state <= (r_cnt == '0) ? ERR : DIV;
                end
                DIV: begin
                    if (w_divGe) begin
                        r_num <= r_num - r_den;
                    end
                    r_x   <= r_x | (XW'(w_divGe) << (32'(r_step) + 2 * FRAC));
                    r_den <= r_den >> 1;
`ifdef BAGGAGE_DROP_DIAG_EN
                    r_height <= r_height | (SW'(w_divGe) << r_step);
`endif
                    if (r_step == 8'd0) begin
                        r_step  <= 8'(SQ - 1);
                        r_state <= SQRT;
                    end else begin
                        r_step <= r_step - 8'd1;
                    end
                end
                SQRT: begin
                    if (w_sqGe) begin
                        r_x   <= r_x - w_trial;
                        r_res <= (r_res >> 1) + r_bit;
                    end else begin
                        r_res <= r_res >> 1;
                    end
                    r_bit <= r_bit >> 2;
                    if (r_step == 8'd0) begin
                        r_state <= DEC;
                    end else begin
                        r_step <= r_step - 8'd1;
                    end
                end
                DEC: begin
                    r_tOut <= w_tVal;
                    r_drop <= w_drop;
                    r_seg  <= w_drop ? {7'h5E, 7'h50, 7'h3F, 7'h73}
                                     : {7'h38, 7'h3F, 7'h39, 7'h76};
`ifdef BAGGAGE_DROP_DIAG_EN
                    r_heightOut <= r_height;
                    r_validCnt  <= 5'(r_cnt);
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                ERR: begin
                    r_tOut <= '1;
                    r_drop <= 1'b0;
                    r_seg  <= {4{7'h40}};
`ifdef BAGGAGE_DROP_DIAG_EN
                    r_heightOut <= '0;
                    r_validCnt  <= '0;
`endif
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign t_out          = r_tOut;
    assign drop_activated = r_drop;
    assign seven_seg1     = r_seg[27:21];
    assign seven_seg2     = r_seg[20:14];
    assign seven_seg3     = r_seg[13:7];
    assign seven_seg4     = r_seg[6:0];
`ifdef BAGGAGE_DROP_DIAG_EN
    assign height_out     = r_heightOut;
    assign valid_cnt      = r_validCnt;
`endif

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Self-checking bench for baggage_drop_seq (default configuration, diagnostics disabled).
module tb_baggage_drop_seq;

    localparam logic [27:0] DROPSEG = {7'h5E, 7'h50, 7'h3F, 7'h73};
    localparam logic [27:0] LOCKSEG = {7'h38, 7'h3F, 7'h39, 7'h76};
    localparam logic [27:0] ERRSEG  = {4{7'h40}};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] sensors;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        busy;
    logic        done;
    logic [15:0] t_out;
    logic        drop_activated;
    logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;

    int total = 0;
    int bad   = 0;

    baggage_drop_seq #(.N_SENS(4), .SW(8), .FRAC(8), .TW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sensors(sensors),
        .t_lim(t_lim), .drop_en(drop_en), .busy(busy), .done(done),
        .t_out(t_out), .drop_activated(drop_activated),
        .seven_seg1(seven_seg1), .seven_seg2(seven_seg2),
        .seven_seg3(seven_seg3), .seven_seg4(seven_seg4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mean of non-zero readings, integer sqrt by search, halve.
    function automatic void model(input logic [31:0] s, input logic [15:0] tl, input logic de,
                                  output logic [15:0] et, output logic ed,
                                  output logic [27:0] eseg, output int elat);
        int sum = 0;
        int cnt = 0;
        longint x;
        longint r;
        for (int i = 0; i < 4; i++) begin
            if (s[i*8 +: 8] != 8'd0) begin
                sum += int'(s[i*8 +: 8]);
                cnt++;
            end
        end
        if (cnt == 0) begin
            et = 16'hFFFF; ed = 1'b0; eseg = ERRSEG; elat = 6;
        end else begin
            x = longint'(sum / cnt) * 65536;
            r = 0;
            while ((r + 1) * (r + 1) <= x) r++;
            et   = 16'(r / 2);
            ed   = de && (et <= tl);
            eseg = ed ? DROPSEG : LOCKSEG;
            elat = 28;
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] s, input logic [15:0] tl, input logic de,
                                 output int lat);
        if (done) begin
            @(posedge clk); #1;
        end
        sensors = s; t_lim = tl; drop_en = de; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        sensors = $urandom;
        t_lim   = 16'($urandom);
        drop_en = 1'($urandom);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic check_run(input string name, input logic [31:0] s, input logic [15:0] tl,
                             input logic de);
        logic [15:0] et; logic ed; logic [27:0] eseg; int elat; int lat;
        model(s, tl, de, et, ed, eseg, elat);
        applyStimulus(s, tl, de, lat);
        total++;
        if (lat !== elat) begin
            bad++; $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        total++;
        if (t_out !== et) begin
            bad++; $display("[TB] FAIL %s t_out: got %h want %h", name, t_out, et);
        end
        total++;
        if (drop_activated !== ed) begin
            bad++; $display("[TB] FAIL %s drop: got %b want %b", name, drop_activated, ed);
        end
        total++;
        if ({seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== eseg) begin
            bad++; $display("[TB] FAIL %s segs: got %h want %h", name,
                            {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, eseg);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL %s busy at done: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sensors = '0; t_lim = '0; drop_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, t_out, drop_activated} !== 19'd0) begin
            bad++; $display("[TB] FAIL reset ctrl: got %h want 0", {busy, done, t_out, drop_activated});
        end
        total++;
        if ({seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== 28'd0) begin
            bad++; $display("[TB] FAIL reset segs: got %h want 0",
                            {seven_seg1, seven_seg2, seven_seg3, seven_seg4});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_run("drop16", {8'd16, 8'd16, 8'd16, 8'd16}, 16'h0200, 1'b1);
        check_run("lock16", {8'd16, 8'd16, 8'd16, 8'd16}, 16'h01FF, 1'b1);
        check_run("avg15",  {8'd0, 8'd20, 8'd0, 8'd10},   16'h0300, 1'b0);
        check_run("allzero", 32'd0, 16'h0300, 1'b1);
        check_run("max255", {4{8'd255}}, 16'hFFFF, 1'b1);
        check_run("eqlim",  {8'd0, 8'd0, 8'd0, 8'd36},    16'h0300, 1'b1);
    endtask

    task automatic test_start_ignored();
        int c = 0; int dones = 0; int busyDrops = 0;
        if (done) begin
            @(posedge clk); #1;
        end
        sensors = {8'd36, 8'd0, 8'd36, 8'd0}; t_lim = 16'h0300; drop_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && c < 200) begin
            @(posedge clk); #1;
            c++;
            if (c == 5) begin start = 1'b1; sensors = {4{8'd255}}; end
            if (c == 6) start = 1'b0;
            if (!done && busy !== 1'b1) busyDrops++;
        end
        total++;
        if (c !== 28) begin
            bad++; $display("[TB] FAIL ignore latency: got %0d want 28", c);
        end
        total++;
        if (t_out !== 16'h0300) begin
            bad++; $display("[TB] FAIL ignore t_out: got %h want 0300", t_out);
        end
        total++;
        if (busyDrops !== 0) begin
            bad++; $display("[TB] FAIL ignore busy early low: got %0d want 0", busyDrops);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        total++;
        if (dones !== 0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL ignore extra done: got %0d busy %b want 0 0", dones, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] et; logic ed; logic [27:0] eseg; int elat; int lat;
        logic [31:0] s2;
        check_run("b2b_first", {8'd100, 8'd200, 8'd50, 8'd7}, 16'h0400, 1'b1);
        s2 = {8'd9, 8'd0, 8'd81, 8'd0};
        model(s2, 16'h0100, 1'b1, et, ed, eseg, elat);
        sensors = s2; t_lim = 16'h0100; drop_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b done-cycle start: busy got %b want 0", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b next-cycle start: busy got %b want 1", busy);
        end
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
        total++;
        if (lat !== elat || t_out !== et || drop_activated !== ed) begin
            bad++; $display("[TB] FAIL b2b second run: got lat=%0d t=%h d=%b want lat=%0d t=%h d=%b",
                            lat, t_out, drop_activated, elat, et, ed);
        end
    endtask

    task automatic test_random();
        logic [31:0] s; logic [15:0] tl; logic de;
        logic [15:0] et; logic ed; logic [27:0] eseg; int elat;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++)
                s[i*8 +: 8] = ($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom_range(1, 255));
            de = ($urandom_range(0, 3) != 0);
            model(s, 16'h0, de, et, ed, eseg, elat);
            case ($urandom_range(0, 3))
                0: tl = 16'($urandom);
                1: tl = et;
                2: tl = et - 16'd1;
                default: tl = et + 16'd1;
            endcase
            check_run("random", s, tl, de);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        if (done) begin
            @(posedge clk); #1;
        end
        sensors = {4{8'd16}}; t_lim = 16'h0200; drop_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, t_out, drop_activated} !== 19'd0 ||
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4} !== 28'd0) begin
            bad++; $display("[TB] FAIL midreset outputs: got %h %h want 0 0",
                            {busy, done, t_out, drop_activated},
                            {seven_seg1, seven_seg2, seven_seg3, seven_seg4});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        total++;
        if (dones !== 0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset stray done: got %0d busy %b want 0 0", dones, busy);
        end
        check_run("after_reset", {4{8'd16}}, 16'h0200, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
